// File: rtl/tpu_seq_pkg.sv
// Shared state encoding and sizing helpers for the TPU matmul sequencer.
package tpu_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_LATCH,
      S_RUN,
      S_DONE
   } seq_state_e;

   localparam int DEFAULT_ADDRESSSIZE   = 10;
   localparam int DEFAULT_MATRIX_SIZE   = 8;
   localparam int DEFAULT_ARRAY_LATENCY = 16;

   // Spare top bit keeps the RUN counter clear of its terminal value.
   function automatic int seq_cnt_width(input int matrix_size, input int array_latency);
      return $clog2(matrix_size + array_latency) + 1;
   endfunction

   localparam int DEFAULT_CNT_W = seq_cnt_width(DEFAULT_MATRIX_SIZE, DEFAULT_ARRAY_LATENCY);

endpackage

// File: rtl/seq_addr_gen.sv
// Base register plus row offset, wrapping modulo 2^AW; output is registered
// and forced to zero whenever the enable is low.
module seq_addr_gen
   import tpu_seq_pkg::*;
#(
   parameter int AW   = DEFAULT_ADDRESSSIZE,
   parameter int STEP = DEFAULT_MATRIX_SIZE
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          load_i,
   input  logic [AW-1:0] base_i,
   input  logic          advance_i,
   input  logic          en_i,
   input  logic [AW-1:0] offset_i,
   output logic [AW-1:0] addr_o
);

   localparam logic [AW-1:0] STEP_C = AW'(STEP);

   logic [AW-1:0] base_q, base_d;
   logic [AW-1:0] addr_q, addr_d;

   always_comb begin
      base_d = base_q;
      if (load_i) begin
         base_d = base_i;
      end else if (advance_i) begin
         base_d = base_q + STEP_C;
      end
      addr_d = en_i ? (base_q + offset_i) : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         base_q <= '0;
         addr_q <= '0;
      end else begin
         base_q <= base_d;
         addr_q <= addr_d;
      end
   end

   assign addr_o = addr_q;

endmodule

// File: rtl/tpu_matmul_sequencer.sv
// Control FSM for one 8x8 systolic matmul tile: pop weights, latch, stream
// activations, write skewed results. TPU_SEQ_CHAIN_EN chains tiles back-to-back.
module tpu_matmul_sequencer
   import tpu_seq_pkg::*;
#(
   parameter int ADDRESSSIZE   = DEFAULT_ADDRESSSIZE,
   parameter int MATRIX_SIZE   = DEFAULT_MATRIX_SIZE,
   parameter int ARRAY_LATENCY = DEFAULT_ARRAY_LATENCY
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [ADDRESSSIZE-1:0] act_base_i,
   input  logic [ADDRESSSIZE-1:0] res_base_i,
   input  logic                   fifo_empty_i,
   output logic                   fifo_read_enable_o,
   output logic                   we_rl_o,
   output logic [ADDRESSSIZE-1:0] sram_address_o,
   output logic                   valid_address_o,
   output logic                   res_write_enable_o,
   output logic [ADDRESSSIZE-1:0] res_address_o,
   output logic                   busy_o,
   output logic                   end_o,
   output logic                   start_rejected_o
);

   localparam int CNT_W = seq_cnt_width(MATRIX_SIZE, ARRAY_LATENCY);
   localparam logic [CNT_W-1:0] MS_C   = CNT_W'(MATRIX_SIZE);
   localparam logic [CNT_W-1:0] AL_C   = CNT_W'(ARRAY_LATENCY);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(ARRAY_LATENCY + MATRIX_SIZE - 1);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] t_q, t_d;

   logic accept, last_run, chain_go;
   logic rd_en, wr_en;
   logic [ADDRESSSIZE-1:0] act_off, res_off;

   logic fre_q, fre_d;
   logic we_q, we_d;
   logic va_q, va_d;
   logic rwe_q, rwe_d;
   logic busy_q, busy_d;
   logic end_q, end_d;
   logic rej_q, rej_d;

   always_comb begin
      accept   = (state_q == S_IDLE) && start_i && !fifo_empty_i;
      last_run = (state_q == S_RUN) && (t_q == LAST_C);
`ifdef TPU_SEQ_CHAIN_EN
      chain_go = last_run && !fifo_empty_i;
`else
      chain_go = 1'b0;
`endif

      state_d = state_q;
      t_d     = t_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_POP;
         S_POP:   state_d = S_LATCH;
         S_LATCH: begin
            state_d = S_RUN;
            t_d     = '0;
         end
         S_RUN: begin
            if (last_run) begin
               t_d     = '0;
               state_d = chain_go ? S_POP : S_DONE;
            end else begin
               t_d = t_q + ONE_C;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes are decoded from the current state and registered, so every
   // output trails the state register by one cycle.
   always_comb begin
      rd_en   = (state_q == S_RUN) && (t_q < MS_C);
      wr_en   = (state_q == S_RUN) && (t_q >= AL_C);
      act_off = ADDRESSSIZE'(t_q);
      res_off = ADDRESSSIZE'(t_q - AL_C);

      fre_d  = (state_q == S_POP);
      we_d   = (state_q == S_LATCH);
      va_d   = rd_en;
      rwe_d  = wr_en;
      busy_d = (state_q != S_IDLE);
      end_d  = (state_q == S_DONE);
      rej_d  = (state_q == S_IDLE) && start_i && fifo_empty_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         t_q     <= '0;
         fre_q   <= 1'b0;
         we_q    <= 1'b0;
         va_q    <= 1'b0;
         rwe_q   <= 1'b0;
         busy_q  <= 1'b0;
         end_q   <= 1'b0;
         rej_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         fre_q   <= fre_d;
         we_q    <= we_d;
         va_q    <= va_d;
         rwe_q   <= rwe_d;
         busy_q  <= busy_d;
         end_q   <= end_d;
         rej_q   <= rej_d;
      end
   end

   seq_addr_gen #(
      .AW   (ADDRESSSIZE),
      .STEP (MATRIX_SIZE)
   ) u_act_addr (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load_i    (accept),
      .base_i    (act_base_i),
      .advance_i (chain_go),
      .en_i      (rd_en),
      .offset_i  (act_off),
      .addr_o    (sram_address_o)
   );

   seq_addr_gen #(
      .AW   (ADDRESSSIZE),
      .STEP (MATRIX_SIZE)
   ) u_res_addr (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load_i    (accept),
      .base_i    (res_base_i),
      .advance_i (chain_go),
      .en_i      (wr_en),
      .offset_i  (res_off),
      .addr_o    (res_address_o)
   );

   assign fifo_read_enable_o = fre_q;
   assign we_rl_o            = we_q;
   assign valid_address_o    = va_q;
   assign res_write_enable_o = rwe_q;
   assign busy_o             = busy_q;
   assign end_o              = end_q;
   assign start_rejected_o   = rej_q;

endmodule

// File: tb/tb_tpu_matmul_sequencer.sv
// Scoreboard bench for tpu_matmul_sequencer: stimulus queues expected strobe
// events and status probes; a negedge monitor consumes and compares them.
module tb_tpu_matmul_sequencer;

   localparam int AW    = 10;
   localparam int MS    = 8;
   localparam int AL    = 16;
   localparam int AMASK = 'h3FF;
   localparam int NOLIM = 100000;

   typedef enum int {EV_POP, EV_LATCH, EV_RD, EV_WR, EV_END, EV_REJ} ev_kind_e;
   typedef struct { int cyc; ev_kind_e kind; int addr; } ev_t;
   localparam int P_BUSY = 0;
   localparam int P_ALL  = 1;
   typedef struct { int cyc; int sel; int exp; } probe_t;

   logic          clk = 1'b0;
   logic          rst, start, fifo_empty;
   logic [AW-1:0] act_base, res_base;
   logic          fifo_read_enable, we_rl, valid_address, res_write_enable;
   logic          busy, end_, start_rejected;
   logic [AW-1:0] sram_address, res_address;

   ev_t    exp_q[$];
   probe_t probe_q[$];
   int     checks = 0;
   int     fails  = 0;
   int     cyc    = 0;
   int     fills  = 0;
   int     pops   = 0;
   bit     mon_en = 1'b0;
   bit     done_req = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (fifo_read_enable === 1'b1) pops <= pops + 1;
   assign fifo_empty = (fills == pops);

   tpu_matmul_sequencer dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .start_i            (start),
      .act_base_i         (act_base),
      .res_base_i         (res_base),
      .fifo_empty_i       (fifo_empty),
      .fifo_read_enable_o (fifo_read_enable),
      .we_rl_o            (we_rl),
      .sram_address_o     (sram_address),
      .valid_address_o    (valid_address),
      .res_write_enable_o (res_write_enable),
      .res_address_o      (res_address),
      .busy_o             (busy),
      .end_o              (end_),
      .start_rejected_o   (start_rejected)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic to_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic push_ev(input int c, input ev_kind_e k, input int a);
      ev_t e;
      e.cyc = c; e.kind = k; e.addr = a;
      exp_q.push_back(e);
   endtask

   task automatic push_probe(input int c, input int sel, input int exp);
      probe_t p;
      p.cyc = c; p.sel = sel; p.exp = exp;
      probe_q.push_back(p);
   endtask

   // A = accept edge; events beyond A+span are not expected (abort cases).
   task automatic push_tile(input int A, input int ab, input int rb, input int span, input bit with_end);
      if (1 <= span) push_ev(A + 1, EV_POP, 0);
      if (2 <= span) push_ev(A + 2, EV_LATCH, 0);
      for (int i = 0; i < MS; i++)
         if (3 + i <= span) push_ev(A + 3 + i, EV_RD, (ab + i) & AMASK);
      for (int i = 0; i < MS; i++)
         if (3 + AL + i <= span) push_ev(A + 3 + AL + i, EV_WR, (rb + i) & AMASK);
      if (with_end && (3 + AL + MS <= span)) push_ev(A + 3 + AL + MS, EV_END, 0);
   endtask

   task automatic accept(input int ab, input int rb, input int span, input bit with_end, output int A);
      A        = cyc + 1;
      act_base = ab[AW-1:0];
      res_base = rb[AW-1:0];
      start    = 1'b1;
      push_tile(A, ab, rb, span, with_end);
      tick(1);
      start    = 1'b0;
      act_base = 10'h155;
      res_base = 10'h2AA;
   endtask

   task automatic got(input ev_kind_e k, input int a);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_%s: got event at cycle %0d addr %0h, required none", k.name(), cyc, a);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.cyc != cyc || e.addr != a) begin
            fails++;
            $display("FAIL event_%s: got %s at cycle %0d addr %0h, required %s at cycle %0d addr %0h",
                     e.kind.name(), k.name(), cyc, a, e.kind.name(), e.cyc, e.addr);
         end
      end
   endtask

   always @(negedge clk) begin : monitor
      probe_t      pr;
      logic [31:0] act;
      if (mon_en) begin
         if (fifo_read_enable === 1'b1) got(EV_POP, 0);
         if (we_rl === 1'b1) got(EV_LATCH, 0);
         if (valid_address === 1'b1) got(EV_RD, int'(sram_address));
         else begin
            checks++;
            if (sram_address !== '0) begin
               fails++;
               $display("FAIL sram_addr_idle: got %0h at cycle %0d, required 0", sram_address, cyc);
            end
         end
         if (res_write_enable === 1'b1) got(EV_WR, int'(res_address));
         else begin
            checks++;
            if (res_address !== '0) begin
               fails++;
               $display("FAIL res_addr_idle: got %0h at cycle %0d, required 0", res_address, cyc);
            end
         end
         if (end_ === 1'b1) got(EV_END, 0);
         if (start_rejected === 1'b1) got(EV_REJ, 0);

         while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
            pr = probe_q.pop_front();
            if (pr.sel == P_BUSY) act = {31'd0, busy};
            else act = {5'd0, busy, end_, start_rejected, fifo_read_enable, we_rl,
                        valid_address, res_write_enable, sram_address, res_address};
            checks++;
            if (pr.cyc != cyc || act !== pr.exp) begin
               fails++;
               $display("FAIL probe_%s: got %0h at cycle %0d, required %0h at cycle %0d",
                        (pr.sel == P_BUSY) ? "busy" : "all_outputs", act, cyc, pr.exp, pr.cyc);
            end
         end
      end
      if (done_req) begin
         checks++;
         if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL events_outstanding: got %0d unconsumed events (next at cycle %0d), required 0",
                     exp_q.size(), exp_q[0].cyc);
         end
         checks++;
         if (probe_q.size() != 0) begin
            fails++;
            $display("FAIL probes_outstanding: got %0d unconsumed probes, required 0", probe_q.size());
         end
         $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
         $finish;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach its summary in time");
      $fatal(1);
   end

   initial begin : stim
      int A;
      int c;
      rst      = 1'b1;
      start    = 1'b0;
      act_base = '0;
      res_base = '0;
      tick(2);
      push_probe(cyc + 1, P_ALL, 0);
      mon_en = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);

      // Basic tile: reads 0..7 at 3..10, writes 0x20..0x27 at 19..26, end at 27
      fills = fills + 1;
      accept('h000, 'h020, NOLIM, 1'b1, A);
      push_probe(A + 1, P_BUSY, 1);
      push_probe(A + 27, P_BUSY, 1);
      push_probe(A + 28, P_BUSY, 0);
      to_cyc(A + 31);

      // Start against an empty FIFO
      c = cyc;
      start = 1'b1;
      push_ev(c + 1, EV_REJ, 0);
      push_probe(c + 1, P_BUSY, 0);
      push_probe(c + 2, P_ALL, 0);
      tick(1);
      start = 1'b0;
      to_cyc(c + 5);

      // Address wrap on both streams
      fills = fills + 1;
      accept('h3FC, 'h3FE, NOLIM, 1'b1, A);
      to_cyc(A + 31);

      // Reset during RUN aborts silently, then a fresh tile runs to completion
      fills = fills + 1;
      accept('h010, 'h030, 12, 1'b0, A);
      to_cyc(A + 12);
      rst = 1'b1;
      push_probe(A + 13, P_ALL, 0);
      tick(1);
      rst = 1'b0;
      tick(1);
      fills = fills + 1;
      accept('h040, 'h060, NOLIM, 1'b1, A);
      push_probe(A + 28, P_BUSY, 0);
      to_cyc(A + 31);

      // Start held high: one tile, next accept at cycle 28 with new bases
      fills = fills + 2;
      A = cyc + 1;
      act_base = 10'h080;
      res_base = 10'h0A0;
      start = 1'b1;
      push_tile(A, 'h080, 'h0A0, NOLIM, 1'b1);
      tick(1);
      act_base = 10'h100;
      res_base = 10'h120;
      push_tile(A + 28, 'h100, 'h120, NOLIM, 1'b1);
      push_probe(A + 28, P_BUSY, 0);
      push_probe(A + 29, P_BUSY, 1);
      to_cyc(A + 28);
      start = 1'b0;
      to_cyc(A + 28 + 31);

`ifdef TPU_SEQ_CHAIN_EN
      // Three chained tiles, bases advancing by 8, single end_
      fills = fills + 3;
      accept('h000, 'h040, NOLIM, 1'b0, A);
      push_tile(A + 26, 'h008, 'h048, NOLIM, 1'b0);
      push_tile(A + 52, 'h010, 'h050, NOLIM, 1'b1);
      for (int k = 1; k <= 79; k++) push_probe(A + k, P_BUSY, 1);
      push_probe(A + 80, P_BUSY, 0);
      to_cyc(A + 83);
`endif

      tick(2);
      done_req = 1'b1;
      tick(3);
   end

endmodule

// File: doc/tpu_matmul_sequencer.md
# tpu_matmul_sequencer

Control FSM for one 8x8 systolic matrix multiply. It pops one weight tile from the weight FIFO and latches it into the PE array. It then streams activation rows from the input SRAM and writes the skewed result rows into the result SRAM. It replaces testbench-driven sequencing of `start`, `fifo_read_enable`, `we_rl`, `valid_address` and `sram_address` inside the TPU top.

## Interface
- `ADDRESSSIZE`, 10, width of all SRAM addresses
- `MATRIX_SIZE`, 8, rows per tile (activation rows streamed, result rows written)
- `ARRAY_LATENCY`, 16, cycles from first `valid_address` cycle to first valid result row at result SRAM input
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  request one tile; sampled only in IDLE
- `act_base`  in  ADDRESSSIZE  first activation row address; captured at accept
- `res_base`  in  ADDRESSSIZE  first result row address; captured at accept
- `fifo_empty`  in  1  weight FIFO empty flag
- `fifo_read_enable`  out  1  weight FIFO pop strobe
- `we_rl`  out  1  weight latch strobe into PE array
- `sram_address`  out  ADDRESSSIZE  activation SRAM read address
- `valid_address`  out  1  activation address valid (row enters array)
- `res_write_enable`  out  1  result SRAM write strobe
- `res_address`  out  ADDRESSSIZE  result SRAM write address
- `busy`  out  1  high in every state except IDLE
- `end_`  out  1  one-cycle done pulse
- `start_rejected`  out  1  one-cycle pulse: start seen in IDLE with FIFO empty

## Operation
- States: IDLE -> POP -> LATCH -> RUN -> DONE -> IDLE.
- IDLE handles `start`:
  - `start`=1 and `fifo_empty`=0: capture bases, go to POP.
  - `start`=1 and `fifo_empty`=1: stay in IDLE, pulse `start_rejected`.
- POP: `fifo_read_enable`=1 for exactly one cycle.
- LATCH: `we_rl`=1 for exactly one cycle, because the FIFO output is registered.
- RUN uses counter t = 0 .. ARRAY_LATENCY+MATRIX_SIZE-1.
  - t < MATRIX_SIZE: `valid_address`=1, `sram_address`=act_base+t.
  - ARRAY_LATENCY <= t < ARRAY_LATENCY+MATRIX_SIZE: `res_write_enable`=1, `res_address`=res_base+(t-ARRAY_LATENCY).
  - The two windows may overlap when ARRAY_LATENCY < MATRIX_SIZE.
- DONE: `end_`=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^ADDRESSSIZE; base+offset wraps silently.
- Counter width is clog2(ARRAY_LATENCY+MATRIX_SIZE)+1.
- `start` while busy is ignored and does not pulse `start_rejected`.
- `act_base`/`res_base` changes after accept have no effect.
- `sram_address` and `res_address` are held at 0 whenever their valid/strobe is low.

## Timing
- Reset: state IDLE; every output 0, including addresses; counters 0.
- `rst` asserted mid-operation aborts on the next edge: all outputs 0, no `end_`, FIFO entry already popped is lost.
- Cycle numbering, with accept at edge 0:
  - POP cycle 1, LATCH cycle 2.
  - RUN cycles 3 .. 2+ARRAY_LATENCY+MATRIX_SIZE.
  - DONE at cycle 3+ARRAY_LATENCY+MATRIX_SIZE; default 27.
- Activation reads: cycles 3..10.
- Result writes: cycles 19..26.
- A new `start` can be accepted in the cycle after DONE (IDLE).
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- `TPU_SEQ_CHAIN_EN` undefined: one tile per accepted `start`.
- `TPU_SEQ_CHAIN_EN` defined, at the last RUN cycle:
  - If `fifo_empty`=0, go to POP instead of DONE.
  - act_base and res_base each advance by MATRIX_SIZE (modulo).
  - `end_` pulses only after the tile where the FIFO was empty at the last RUN cycle.
  - `busy` stays high across chained tiles.

## Structure
- Shared package `tpu_seq_pkg`:
  - state enum (IDLE, POP, LATCH, RUN, DONE)
  - default ARRAY_LATENCY
  - counter-width constant derived from MATRIX_SIZE and ARRAY_LATENCY
- One sub-module, `seq_addr_gen`:
  - base register plus offset with modulo wrap and zero-when-idle output.
  - Instantiated twice: activation and result.

## Test plan
- Default params, FIFO holds 1 tile, act_base=0, res_base=0x20, start pulse at cycle 0:
  - `fifo_read_enable` at cycle 1, `we_rl` at cycle 2.
  - `sram_address` 0..7 with `valid_address` at cycles 3..10.
  - `res_address` 0x20..0x27 at cycles 19..26.
  - `end_` at 27, `busy` low at 28.
- `start` with `fifo_empty`=1: `start_rejected` for one cycle, `busy` stays 0, no strobes.
- act_base=0x3FC: addresses 0x3FC,0x3FD,0x3FE,0x3FF,0x000..0x003.
- `rst` asserted at cycle 12 (mid-RUN): next cycle all outputs 0, state IDLE, no `end_`; a fresh `start` then runs a full sequence.
- `start` held high through a whole run: exactly one tile, then a second accept at cycle 28 if the FIFO is non-empty.
- With `TPU_SEQ_CHAIN_EN`, 3 tiles in FIFO, act_base=0, res_base=0x40:
  - activation bases 0, 8, 16; result bases 0x40, 0x48, 0x50.
  - single `end_` after the third tile; `busy` continuously high.
